unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, word-wide, synchronous-read memory of MEM_SIZE words (IMEM_SIZE instruction words followed by DMEM_SIZE data words) between the IF-stage fetch port and the MEM-stage data port of the 5-stage RV32I core.
- Arbitrates per cycle; data port has priority by default.
- Translates byte addresses to word indices and range-checks them.
- Returns responses with fixed 1-cycle latency.

Parameters:
- XLEN, 32, data/address width
- ADDR_SHIFT, 2, byte-to-word shift
- IMEM_SIZE, 65536, instruction region size in words (256 KiB)
- DMEM_SIZE, 65536, data region size in words (256 KiB)
- DMEM_BASE, 32'h0004_0000, byte base address of the data region as seen by the data port
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  XLEN  fetch byte address
- if_req_ready  out  1  fetch accepted this cycle
- if_rsp_valid  out  1  fetch response
- if_rsp_data  out  XLEN  instruction word
- if_rsp_err  out  1  fetch fault (misaligned or out of range)
- dm_req_valid  in  1  data request
- dm_req_we  in  1  1 = store, 0 = load
- dm_req_be  in  4  byte enables for stores
- dm_req_addr  in  XLEN  data byte address
- dm_req_wdata  in  XLEN  store data, already lane-aligned by the LSU
- dm_req_ready  out  1  data accepted this cycle
- dm_rsp_valid  out  1  data response (load data or store acknowledge)
- dm_rsp_rdata  out  XLEN  load data; 0 for stores and faults
- dm_rsp_err  out  1  data fault (out of range)
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables
- mem_addr  out  $clog2(IMEM_SIZE+DMEM_SIZE)  word index
- mem_wdata  out  XLEN  write data
- mem_rdata  in  XLEN  read data, valid the cycle after mem_en

Behaviour:
- Reset (async assert, release on clk edge): all outputs 0, owner register = NONE, starvation counter = 0. A response in flight is discarded; nothing is emitted after reset.
- Grant (combinational):
  - dm_req_ready = dm_req_valid.
  - if_req_ready = if_req_valid & ~dm_req_valid.
  - At most one accept per cycle.
  - Acceptance does not depend on an outstanding response, so a new access can issue every cycle.
- Fetch decode:
  - idx = addr >> ADDR_SHIFT.
  - Fault if addr[1:0] != 0 or idx >= IMEM_SIZE.
  - Otherwise mem_addr = idx, mem_we = 0.
- Data decode:
  - off = addr - DMEM_BASE (modulo 2^XLEN); idx = off >> ADDR_SHIFT.
  - Fault if addr < DMEM_BASE or idx >= DMEM_SIZE.
  - Otherwise mem_addr = IMEM_SIZE + idx.
  - mem_we = dm_req_we ? dm_req_be : 4'b0; mem_wdata = dm_req_wdata.
  - addr[1:0] is ignored; lane handling belongs to the LSU.
- mem_en = accept & ~fault. A faulting request is still accepted but never touches memory.
- Owner register, updated each edge: NONE / IF / IF_ERR / DM_RD / DM_WR / DM_ERR, from the accepted request.
- Response, cycle N+1 after accept at cycle N, driven from the owner register:
  - IF: if_rsp_valid = 1, if_rsp_data = mem_rdata.
  - DM_RD: dm_rsp_valid = 1, dm_rsp_rdata = mem_rdata.
  - DM_WR: dm_rsp_valid = 1, dm_rsp_rdata = 0.
  - *_ERR: rsp_valid = 1, err = 1, data = 0.
  - Responses are single-cycle pulses with no backpressure.
- Store followed by load to the same word on consecutive cycles returns the new data; the memory is write-first.
- No combinational path from mem_rdata to any ready signal.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- When defined:
  - The counter increments when a data accept occurs while if_req_valid = 1.
  - It clears on any fetch accept or when if_req_valid = 0.
  - When counter == STARVE_LIMIT, grant inverts for one cycle: if_req_ready = if_req_valid and dm_req_ready = 0.
  - The counter clears after that fetch is accepted.
- When undefined: strict data priority; the counter is not instantiated.

Test Plan:
- Fetch only, addr 0x0000_0010, mem word 4 = 0x0000_0013 -> if_req_ready = 1 same cycle, mem_addr = 4; next cycle if_rsp_valid = 1, if_rsp_data = 0x0000_0013.
- Store to 0x0004_0008, be = 4'b0011, wdata = 0xAAAA_5555, then load same address next cycle -> mem_addr = 65538, mem_we = 0011; store ack with rdata 0; load returns 0x????_5555 with the old upper half intact.
- Simultaneous fetch 0x100 and load 0x0004_0000 -> dm granted, if_req_ready = 0; fetch granted the cycle after dm drops valid.
- Fetch 0x0000_0102 and data load 0x0000_0100 -> each accepted; next cycle err = 1, data 0, mem_en = 0 at accept.
- Fetch valid with dm_req_valid held for 10 cycles -> without macro, fetch never granted; with MEM_ARB_FAIRNESS_EN and STARVE_LIMIT = 4, fetch granted in cycle 5 and dm_req_ready = 0 that cycle.
- rst asserted the cycle after a load accept -> dm_rsp_valid stays 0; all outputs 0 during reset.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, word-wide, synchronous-read memory between the
// IF-stage fetch port and the MEM-stage data port of the RV32I core. The
// memory holds IMEM_SIZE instruction words followed by DMEM_SIZE data words.
// One request is accepted per cycle (data port wins by default). Byte
// addresses are translated to word indices and range-checked; faulting
// requests are accepted but never touch memory. Every accepted request
// gets exactly one response pulse on the following cycle.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   if_req_valid/addr, if_req_ready  fetch request handshake
//   if_rsp_valid/data/err            fetch response (cycle after accept)
//   dm_req_valid/we/be/addr/wdata    data request (store data lane-aligned)
//   dm_req_ready                     data accept
//   dm_rsp_valid/rdata/err           data response (load data or store ack)
//   mem_en/we/addr/wdata             memory access (word index address)
//   mem_rdata                        memory read data, valid cycle after mem_en
//
// Optional build macro:
//   MEM_ARB_FAIRNESS_EN  adds a starvation counter; after STARVE_LIMIT
//                        consecutive data grants with a fetch waiting, the
//                        grant flips to the fetch port for one cycle.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int               XLEN         = 32,
    parameter int               ADDR_SHIFT   = 2,
    parameter int               IMEM_SIZE    = 65536,
    parameter int               DMEM_SIZE    = 65536,
    parameter logic [XLEN-1:0]  DMEM_BASE    = 32'h0004_0000,
    parameter int               STARVE_LIMIT = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   if_req_valid,
    input  logic [XLEN-1:0]                        if_req_addr,
    output logic                                   if_req_ready,
    output logic                                   if_rsp_valid,
    output logic [XLEN-1:0]                        if_rsp_data,
    output logic                                   if_rsp_err,

    input  logic                                   dm_req_valid,
    input  logic                                   dm_req_we,
    input  logic [3:0]                             dm_req_be,
    input  logic [XLEN-1:0]                        dm_req_addr,
    input  logic [XLEN-1:0]                        dm_req_wdata,
    output logic                                   dm_req_ready,
    output logic                                   dm_rsp_valid,
    output logic [XLEN-1:0]                        dm_rsp_rdata,
    output logic                                   dm_rsp_err,

    output logic                                   mem_en,
    output logic [3:0]                             mem_we,
    output logic [$clog2(IMEM_SIZE+DMEM_SIZE)-1:0] mem_addr,
    output logic [XLEN-1:0]                        mem_wdata,
    input  logic [XLEN-1:0]                        mem_rdata
);

    localparam int MEM_AW = $clog2(IMEM_SIZE + DMEM_SIZE);

    localparam logic [XLEN-1:0]   IMEM_WORDS = XLEN'(IMEM_SIZE);
    localparam logic [XLEN-1:0]   DMEM_WORDS = XLEN'(DMEM_SIZE);
    localparam logic [MEM_AW-1:0] DMEM_OFS   = MEM_AW'(IMEM_SIZE);

    // Who the response slot belongs to on the next cycle.
    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_IF,
        OWN_IF_ERR,
        OWN_DM_RD,
        OWN_DM_WR,
        OWN_DM_ERR
    } owner_e;

    owner_e owner_q, owner_d;

    logic [XLEN-1:0] ifIdx;
    logic [XLEN-1:0] dmOff;
    logic [XLEN-1:0] dmIdx;
    logic            ifFault;
    logic            dmFault;
    logic            grantFlip;
    logic            ifAccept;
    logic            dmAccept;

    // Address decode for both ports. The data offset wraps modulo 2^XLEN,
    // so addresses below DMEM_BASE are caught by the explicit compare.
    always_comb begin
        ifIdx   = if_req_addr >> ADDR_SHIFT;
        ifFault = (if_req_addr[ADDR_SHIFT-1:0] != '0) || (ifIdx >= IMEM_WORDS);
        dmOff   = dm_req_addr - DMEM_BASE;
        dmIdx   = dmOff >> ADDR_SHIFT;
        dmFault = (dm_req_addr < DMEM_BASE) || (dmIdx >= DMEM_WORDS);
    end

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;

    // Grant flips to the fetch port once the limit is reached and a fetch
    // is still waiting.
    assign grantFlip = (starve_q == STARVE_MAX) && if_req_valid;

    // Count data grants that bypass a waiting fetch; any fetch grant or an
    // idle fetch port restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (ifAccept || !if_req_valid) begin
            starve_d = '0;
        end else if (dmAccept && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign grantFlip = 1'b0;
`endif

    // Grant is purely a function of the request valids (and the fairness
    // flip), never of mem_rdata or an outstanding response. Accepts are
    // held off while in reset so every output reads zero.
    always_comb begin
        dmAccept = dm_req_valid && !grantFlip && !rst;
        ifAccept = if_req_valid && (!dm_req_valid || grantFlip) && !rst;
    end

    assign dm_req_ready = dmAccept;
    assign if_req_ready = ifAccept;

    // Memory strobe and owner for the accepted request. Faulting requests
    // are accepted but leave the memory untouched.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (dmAccept) begin
            if (dmFault) begin
                owner_d = OWN_DM_ERR;
            end else begin
                mem_en    = 1'b1;
                mem_we    = dm_req_we ? dm_req_be : 4'b0000;
                mem_addr  = DMEM_OFS + dmIdx[MEM_AW-1:0];
                mem_wdata = dm_req_wdata;
                owner_d   = dm_req_we ? OWN_DM_WR : OWN_DM_RD;
            end
        end else if (ifAccept) begin
            if (ifFault) begin
                owner_d = OWN_IF_ERR;
            end else begin
                mem_en   = 1'b1;
                mem_addr = ifIdx[MEM_AW-1:0];
                owner_d  = OWN_IF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // One-cycle response pulses driven from the owner register; data is
    // forced to zero for store acks and faults.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        if_rsp_err   = 1'b0;
        dm_rsp_valid = 1'b0;
        dm_rsp_rdata = '0;
        dm_rsp_err   = 1'b0;
        case (owner_q)
            OWN_IF: begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = mem_rdata;
            end
            OWN_IF_ERR: begin
                if_rsp_valid = 1'b1;
                if_rsp_err   = 1'b1;
            end
            OWN_DM_RD: begin
                dm_rsp_valid = 1'b1;
                dm_rsp_rdata = mem_rdata;
            end
            OWN_DM_WR: begin
                dm_rsp_valid = 1'b1;
            end
            OWN_DM_ERR: begin
                dm_rsp_valid = 1'b1;
                dm_rsp_err   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed bench for unified_mem_arbiter with a behavioural write-first
// memory attached to the mem_* port and a reference model that predicts
// grants, memory strobes and responses. Expected responses are queued at
// accept time and popped one cycle later when the DUT should answer.
// Honours MEM_ARB_FAIRNESS_EN if it is defined for the build.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [3:0]  dm_req_be;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        dm_rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_valid(if_req_valid),
        .if_req_addr (if_req_addr),
        .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_data (if_rsp_data),
        .if_rsp_err  (if_rsp_err),
        .dm_req_valid(dm_req_valid),
        .dm_req_we   (dm_req_we),
        .dm_req_be   (dm_req_be),
        .dm_req_addr (dm_req_addr),
        .dm_req_wdata(dm_req_wdata),
        .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid),
        .dm_rsp_rdata(dm_rsp_rdata),
        .dm_rsp_err  (dm_rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t ifQ[$];
    rsp_t dmQ[$];

    int vectors     = 0;
    int miscompares = 0;
    int starveCnt   = 0;

    logic [31:0] refMem [0:131071];
    logic [31:0] simMem [0:131071];
    logic        preEn = 1'b0;
    logic [16:0] preAddr = '0;
    logic [31:0] preData = '0;
    logic [31:0] memWord;

    // Write-first synchronous memory driven by the DUT; a backdoor preload
    // path is used only while the DUT is held in reset.
    always @(posedge clk) begin
        if (preEn) begin
            simMem[preAddr] <= preData;
        end else if (mem_en) begin
            memWord = simMem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) memWord[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            simMem[mem_addr] <= memWord;
            mem_rdata        <= memWord;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [16:0] a, input logic [31:0] d);
        refMem[a] = d;
        preEn     = 1'b1;
        preAddr   = a;
        preData   = d;
        @(posedge clk);
        @(negedge clk);
        preEn     = 1'b0;
    endtask

    task automatic checkOutput();
        rsp_t r;
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(ifQ.size() != 0));
        if (ifQ.size() != 0) begin
            r = ifQ.pop_front();
            chk("if_rsp_err", 32'(if_rsp_err), 32'(r.err));
            chk("if_rsp_data", if_rsp_data, r.data);
        end
        chk("dm_rsp_valid", 32'(dm_rsp_valid), 32'(dmQ.size() != 0));
        if (dmQ.size() != 0) begin
            r = dmQ.pop_front();
            chk("dm_rsp_err", 32'(dm_rsp_err), 32'(r.err));
            chk("dm_rsp_rdata", dm_rsp_rdata, r.data);
        end
    endtask

    // One cycle: drive at the falling edge, predict, check the combinational
    // grant/memory outputs, clock, then check the responses.
    task automatic applyStimulus(input logic ifV, input logic [31:0] ifA,
                                 input logic dmV, input logic dmWe,
                                 input logic [3:0] dmBe, input logic [31:0] dmA,
                                 input logic [31:0] dmWd);
        logic        flip, expIfRdy, expDmRdy, ifF, dmF, expEn;
        logic [31:0] ifIdx, dmIdx, expAddr, w;
        logic [3:0]  expWe;
        if_req_valid = ifV;
        if_req_addr  = ifA;
        dm_req_valid = dmV;
        dm_req_we    = dmWe;
        dm_req_be    = dmBe;
        dm_req_addr  = dmA;
        dm_req_wdata = dmWd;

        flip = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
        flip = (starveCnt == STARVE) && ifV;
`endif
        expIfRdy = ifV && (!dmV || flip);
        expDmRdy = dmV && !flip;
        ifIdx    = ifA >> 2;
        ifF      = (ifA[1:0] != 2'b00) || (ifIdx >= 32'd65536);
        dmIdx    = (dmA - 32'h0004_0000) >> 2;
        dmF      = (dmA < 32'h0004_0000) || (dmIdx >= 32'd65536);
        expEn    = 1'b0;
        expAddr  = '0;
        expWe    = 4'b0000;

        if (expDmRdy) begin
            if (dmF) begin
                dmQ.push_back('{err: 1'b1, data: 32'h0});
            end else begin
                expEn   = 1'b1;
                expAddr = 32'd65536 + dmIdx;
                expWe   = dmWe ? dmBe : 4'b0000;
                if (dmWe) begin
                    w = refMem[expAddr];
                    for (int b = 0; b < 4; b++) begin
                        if (dmBe[b]) w[8*b +: 8] = dmWd[8*b +: 8];
                    end
                    refMem[expAddr] = w;
                    dmQ.push_back('{err: 1'b0, data: 32'h0});
                end else begin
                    dmQ.push_back('{err: 1'b0, data: refMem[expAddr]});
                end
            end
        end else if (expIfRdy) begin
            if (ifF) begin
                ifQ.push_back('{err: 1'b1, data: 32'h0});
            end else begin
                expEn   = 1'b1;
                expAddr = ifIdx;
                ifQ.push_back('{err: 1'b0, data: refMem[ifIdx]});
            end
        end

`ifdef MEM_ARB_FAIRNESS_EN
        if (expIfRdy || !ifV) starveCnt = 0;
        else if (expDmRdy && starveCnt != STARVE) starveCnt++;
`endif

        #1;
        chk("if_req_ready", 32'(if_req_ready), 32'(expIfRdy));
        chk("dm_req_ready", 32'(dm_req_ready), 32'(expDmRdy));
        chk("mem_en", 32'(mem_en), 32'(expEn));
        if (expEn) begin
            chk("mem_addr", 32'(mem_addr), expAddr);
            chk("mem_we", 32'(mem_we), 32'(expWe));
            if (expWe != 4'b0000) chk("mem_wdata", mem_wdata, dmWd);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, " if_req_ready"}, 32'(if_req_ready), 32'h0);
        chk({tag, " dm_req_ready"}, 32'(dm_req_ready), 32'h0);
        chk({tag, " mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, " if_rsp"}, {29'b0, if_rsp_valid, if_rsp_err, |if_rsp_data}, 32'h0);
        chk({tag, " dm_rsp"}, {29'b0, dm_rsp_valid, dm_rsp_err, |dm_rsp_rdata}, 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        dm_req_valid = 1'b0;
        dm_req_we    = 1'b0;
        dm_req_be    = 4'b0000;
        dm_req_addr  = '0;
        dm_req_wdata = '0;
        @(negedge clk);

        preload(17'd4,      32'h0000_0013);
        preload(17'd64,     32'h0000_0093);
        preload(17'd65535,  32'h0000_006F);
        preload(17'd65536,  32'hCAFE_F00D);
        preload(17'd65538,  32'h1234_BEEF);
        preload(17'd131071, 32'h5A5A_A5A5);

        // Requests presented while in reset must be ignored.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        dm_req_valid = 1'b1;
        dm_req_addr  = 32'h0004_0000;
        #1;
        checkAllZero("reset");
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Plain fetch.
        applyStimulus(1, 32'h0000_0010, 0, 0, 4'b0000, 32'h0, 32'h0);
        // Partial store then load of the same word on the next cycle.
        applyStimulus(0, 32'h0, 1, 1, 4'b0011, 32'h0004_0008, 32'hAAAA_5555);
        applyStimulus(0, 32'h0, 1, 0, 4'b0000, 32'h0004_0008, 32'h0);
        // Contention: data held for ten cycles, then the fetch goes through.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 32'h0000_0100, 1, 0, 4'b0000, 32'h0004_0000, 32'h0);
        end
        applyStimulus(1, 32'h0000_0100, 0, 0, 4'b0000, 32'h0, 32'h0);
        // Faults: misaligned fetch, data below the region, faulting store.
        applyStimulus(1, 32'h0000_0102, 0, 0, 4'b0000, 32'h0, 32'h0);
        applyStimulus(0, 32'h0, 1, 0, 4'b0000, 32'h0000_0100, 32'h0);
        applyStimulus(0, 32'h0, 1, 1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF);
        // Region edges.
        applyStimulus(1, 32'h0003_FFFC, 0, 0, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1, 32'h0004_0000, 0, 0, 4'b0000, 32'h0, 32'h0);
        applyStimulus(0, 32'h0, 1, 0, 4'b0000, 32'h0007_FFFC, 32'h0);
        applyStimulus(0, 32'h0, 1, 0, 4'b0000, 32'h0008_0000, 32'h0);
        // Misaligned data address is still a valid word access.
        applyStimulus(0, 32'h0, 1, 0, 4'b0000, 32'h0004_000B, 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0);

        // Reset right after a load accept discards the pending response.
        if_req_valid = 1'b0;
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b0;
        dm_req_addr  = 32'h0004_0000;
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        ifQ.delete();
        dmQ.delete();
        starveCnt    = 0;
        dm_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0);
        applyStimulus(1, 32'h0000_0010, 0, 0, 4'b0000, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
